// File: rtl/datapath_pkg.sv
// StateDefs: ALU function encodings shared by the control unit and the datapath.
package StateDefs;
    typedef enum logic [2:0] {
        ALU_ZERO, ALU_ADD, ALU_SUB, ALU_PASSA, ALU_XOR, ALU_OR, ALU_AND, ALU_INC
    } AluOp;
endpackage

// File: rtl/datapath_register_file.sv
// register_file: two asynchronous read ports, one synchronous write port, synchronous clear.
module register_file #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic          w_en,
    input  logic [AW-1:0] w_addr,
    input  logic [W-1:0]  w_data,
    output logic [W-1:0]  ra_data,
    output logic [W-1:0]  rb_data
);
    logic [W-1:0] regs_q [2**AW];
    logic [W-1:0] regs_d [2**AW];

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

    always_comb begin
        regs_d = regs_q;
        if (w_en) regs_d[w_addr] = w_data;
        if (!reset_n) regs_d = '{default: '0};
    end

    always_ff @(posedge clk) regs_q <= regs_d;
endmodule

// File: rtl/datapath.sv
// datapath: register file, data memory, write-back mux and 8-function ALU driven by the control unit.
module datapath
    import StateDefs::*;
#(
    parameter int DATA_W = 16,
    parameter int D_AW   = 8,
    parameter int RF_AW  = 4
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic [D_AW-1:0]   D_addr,
    input  logic              D_wr,
    input  logic              RF_s,
    input  logic [RF_AW-1:0]  RF_Ra_addr,
    input  logic [RF_AW-1:0]  RF_Rb_addr,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_W_addr,
    input  logic [2:0]        Alu_s0,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic [DATA_W-1:0] Alu_out,
    output logic              Zero
);
    logic [DATA_W-1:0] mem_q [2**D_AW];
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] wb_data;

    register_file #(.W(DATA_W), .AW(RF_AW)) u_rf (
        .clk     (Clk),
        .reset_n (ResetN),
        .ra_addr (RF_Ra_addr),
        .rb_addr (RF_Rb_addr),
        .w_en    (RF_W_en),
        .w_addr  (RF_W_addr),
        .w_data  (wb_data),
        .ra_data (Ra_data),
        .rb_data (Rb_data)
    );

    always_comb begin
        case (AluOp'(Alu_s0))
            ALU_ADD:   Alu_out = Ra_data + Rb_data;
            ALU_SUB:   Alu_out = Ra_data - Rb_data;
            ALU_PASSA: Alu_out = Ra_data;
            ALU_XOR:   Alu_out = Ra_data ^ Rb_data;
            ALU_OR:    Alu_out = Ra_data | Rb_data;
            ALU_AND:   Alu_out = Ra_data & Rb_data;
            ALU_INC:   Alu_out = Ra_data + 1'b1;
            default:   Alu_out = '0;
        endcase
    end

    assign wb_data = RF_s ? mem_rdata_q : Alu_out;
    assign Zero    = zero_q;

    always_comb begin
        mem_rdata_d = ResetN ? mem_q[D_addr] : '0;
        zero_d      = !ResetN ? 1'b0 : (RF_W_en && !RF_s) ? (Alu_out == '0) : zero_q;
    end

    always_ff @(posedge Clk) begin
        mem_rdata_q <= mem_rdata_d;
        zero_q      <= zero_d;
        // contents survive reset; only the write is blocked
        if (ResetN && D_wr) mem_q[D_addr] <= Ra_data;
    end
endmodule

// File: doc/datapath.md
# datapath

Processor datapath that executes the control signals issued by the control-unit state machine. It contains a 16×16 register file, a 256×16 data memory, a write-back mux and an 8-function ALU. It is the direct downstream consumer of the control unit: every control output drives exactly one datapath input. It returns the ALU result, the read-port data and a zero flag for display and debug.

## Interface
- `DATA_W`, 16: data word width.
- `D_AW`, 8: data-memory address width (256 words).
- `RF_AW`, 4: register-file address width (16 registers).
- `Clk` in 1: single clock, rising edge.
- `ResetN` in 1: synchronous, active-low reset.
- `D_addr` in 8: data-memory address.
- `D_wr` in 1: data-memory write enable.
- `RF_s` in 1: write-back select; 1 = memory read data, 0 = ALU result.
- `RF_Ra_addr` in 4: register-file A read address.
- `RF_Rb_addr` in 4: register-file B read address.
- `RF_W_en` in 1: register-file write enable.
- `RF_W_addr` in 4: register-file write address.
- `Alu_s0` in 3: ALU function select.
- `Ra_data` out 16: A-port read data.
- `Rb_data` out 16: B-port read data.
- `Alu_out` out 16: combinational ALU result.
- `Zero` out 1: registered flag, set when the last ALU write-back result was 0.

## Operation
- **Register file**
  - Two asynchronous read ports.
  - One synchronous write port: when `RF_W_en`=1 at a rising edge, `RF[RF_W_addr]` ← write-back value.
  - The write-back value is `RF_s ? mem_rdata : Alu_out`.
- **ALU** (A=`Ra_data`, B=`Rb_data`; all arithmetic modulo 2^16, no carry out):
  - 0: result 0
  - 1: A+B
  - 2: A−B
  - 3: A
  - 4: A^B
  - 5: A|B
  - 6: A&B
  - 7: A+1
- **Data memory**
  - Synchronous write: when `D_wr`=1, `mem[D_addr]` ← `Ra_data`.
  - Synchronous read: `mem_rdata` ← `mem[D_addr]` every cycle, so read data appears one cycle after the address.
- **Zero flag**: on an edge with `RF_W_en`=1 and `RF_s`=0, `Zero` ← (`Alu_out`==0). Otherwise it holds its value.
- **Reset** (`ResetN`=0 at an edge):
  - All 16 registers ← 0; `mem_rdata` ← 0; `Zero` ← 0.
  - Register-file and memory writes in that cycle are suppressed.
  - Memory contents are not cleared.
- **Reset arriving mid-Load** (between the address cycle and the write-back cycle): the pending load is abandoned and no register is written.
- **Out-of-range addresses** cannot occur; all address widths exactly cover their storage.

## Timing
- **ADD/SUB**: same-cycle combinational path, `RF_Ra_addr`/`RF_Rb_addr` → `Alu_out`. The destination register holds the result after the edge that ends the cycle with `RF_W_en`=1. Latency is 1 edge.
- **Load**:
  - Cycle N (Load_A): `D_addr` is valid.
  - Cycle N+1 (Load_B): `D_addr` is held, `RF_s`=1, `RF_W_en`=1; `mem_rdata` is valid throughout.
  - The register is written at the end of N+1. Latency is 2 edges.
- **Store**: `mem[D_addr]` is updated at the edge ending the `D_wr` cycle.
- **Register read during write, same address, same cycle**: the read port returns the old value; the new value is visible in the next cycle.
- **Memory read and write to the same address in one cycle**: read-before-write; `mem_rdata` gets the old word.
- **Write-back data during a Load**: `RF_s`=1 with `RF_W_en`=1 in the first cycle after reset writes `mem_rdata`=0.
- **Reset values** (one edge after `ResetN` low):
  - `Ra_data`=`Rb_data`=0
  - `Alu_out`=`f(Alu_s0,0,0)`
  - `Zero`=0

## Structure
- Add `typedef enum logic [2:0] AluOp {ALU_ZERO, ALU_ADD, ALU_SUB, ALU_PASSA, ALU_XOR, ALU_OR, ALU_AND, ALU_INC}` to the shared `StateDefs` package. The control unit's 1/2 encodings for ADD/SUB stay consistent with it.
- Sub-module `register_file`: 16×16 storage, 2 async reads, 1 sync write, synchronous clear.
- The ALU and data memory live inline in `datapath`.

## Test plan
- **Reset**: hold `ResetN`=0 for 2 cycles with `RF_W_en`=1 and `D_wr`=1 → all registers read 0, `Zero`=0, no memory word changed.
- **Add**:
  - Preload R1=0x0005 and R2=0x0003 via `RF_s`=0, `Alu_s0`=7 sequences.
  - Drive Ra=1, Rb=2, `Alu_s0`=1, W=3, `RF_W_en`=1.
  - → R3=0x0008, `Zero`=0.
- **Sub wrap**: R1=0x0003, R2=0x0005, `Alu_s0`=2 → R4=0xFFFE. Then R1−R1 → `Zero`=1.
- **Store then load**:
  - Store: `D_wr`=1, `D_addr`=0x2A, Ra=R3 (0x0008).
  - Load: `D_addr`=0x2A for 2 cycles, `RF_s`=1, `RF_W_en` in cycle 2, W=5.
  - → R5=0x0008. `Zero` is unchanged by the load.
- **Hazards**:
  - Write R6 and read R6 in the same cycle → the old value is returned.
  - `D_wr` with a read of the same address → `mem_rdata` is the old word; the new word appears on the next cycle.
- **Reset mid-Load**: assert `ResetN`=0 in the Load_B cycle → destination register = 0; memory word is intact.
